mem_access: RTL and testbench

Load/store unit sitting directly downstream of the execute/control stage. It accepts that stage's memory request (read/write enable, byte address, store data, access size, signedness, destination register) and runs one transaction on the data-memory bus. It performs byte-lane steering, load sign/zero extension and misalignment checks, and returns load results to the register file. It stalls the PC via `hold_o` while a transaction is in flight.

---
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 159 +++++++++++++++
 tb/tb_mem_access.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Request attributes are held stable by the master until gnt is seen.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wstrb, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wstrb, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access.sv
// Load/store unit: one bus transaction per accepted request, with lane steering,
// load extension, misalignment drop and a request-to-completion timeout.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_re,
    input  logic         mem_we,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_wdata,
    input  logic [1:0]   byte_sel,
    input  logic         un_sign,
    input  logic [4:0]   rd_addr,
    mem_access_if.master bus,
    output logic         rd_we,
    output logic [4:0]   rd_waddr,
    output logic [31:0]  rd_wdata,
    output logic         hold,
    output logic         misalign,
    output logic         bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state_reg, state_next;
    logic        we_reg, sign_reg, load_ok_reg, mis_reg, err_reg;
    logic [31:0] addr_reg, wdata_reg, result_reg;
    logic [1:0]  size_reg;
    logic [4:0]  rd_reg;
    logic [3:0]  wstrb_reg;
    logic [7:0]  cnt_reg;

    logic        valid_req, misaligned, timeout_hit;
    logic [3:0]  lane_strb;
    logic [31:0] lane_data, shifted, load_ext;

    assign valid_req   = (mem_re | mem_we) && (byte_sel != 2'b11);
    assign misaligned  = ((byte_sel == 2'b01) && mem_addr[0]) ||
                         ((byte_sel == 2'b10) && (mem_addr[1:0] != 2'b00));
    assign timeout_hit = (cnt_reg == 8'(TIMEOUT - 1));

    always_comb begin
        lane_strb = 4'b1111;
        lane_data = mem_wdata;
        case (byte_sel)
            2'b00: begin
                lane_strb = 4'b0001 << mem_addr[1:0];
                lane_data = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                lane_strb = 4'b0011 << {mem_addr[1], 1'b0};
                lane_data = {2{mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the captured address/size so it can be applied as rdata arrives.
    always_comb begin
        shifted = bus.rdata >> {addr_reg[1:0], 3'b000};
        case (size_reg)
            2'b00:   load_ext = sign_reg ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = sign_reg ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = bus.rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Completion is tested before the timeout so a grant/rvalid on the last cycle wins.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (valid_req) state_next = misaligned ? DONE : REQ;
            REQ: begin
                if (bus.gnt)          state_next = we_reg ? DONE : RESP;
                else if (timeout_hit) state_next = DONE;
            end
            RESP: begin
                if (bus.rvalid)       state_next = DONE;
                else if (timeout_hit) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg      <= 1'b0;
            sign_reg    <= 1'b0;
            load_ok_reg <= 1'b0;
            mis_reg     <= 1'b0;
            err_reg     <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            result_reg  <= '0;
            size_reg    <= '0;
            rd_reg      <= '0;
            wstrb_reg   <= '0;
            cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: if (valid_req) begin
                    we_reg      <= mem_we;
                    sign_reg    <= un_sign;
                    addr_reg    <= mem_addr;
                    size_reg    <= byte_sel;
                    rd_reg      <= rd_addr;
                    wdata_reg   <= lane_data;
                    wstrb_reg   <= mem_we ? lane_strb : 4'b0000;
                    cnt_reg     <= '0;
                    mis_reg     <= misaligned;
                    err_reg     <= 1'b0;
                    load_ok_reg <= 1'b0;
                    result_reg  <= '0;
                end
                REQ: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (!bus.gnt && timeout_hit) err_reg <= 1'b1;
                end
                RESP: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (bus.rvalid) begin
                        result_reg  <= load_ext;
                        load_ok_reg <= 1'b1;
                    end else if (timeout_hit) begin
                        err_reg <= 1'b1;
                    end
                end
                default: begin
                    mis_reg     <= 1'b0;
                    err_reg     <= 1'b0;
                    load_ok_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.req   = (state_reg == REQ);
        bus.we    = (state_reg == REQ) && we_reg;
        bus.addr  = (state_reg == REQ) ? {addr_reg[31:2], 2'b00} : 32'b0;
        bus.wstrb = (state_reg == REQ) ? wstrb_reg : 4'b0000;
        bus.wdata = (state_reg == REQ) ? wdata_reg : 32'b0;
        rd_we     = (state_reg == DONE) && load_ok_reg;
        rd_waddr  = rd_we ? rd_reg : 5'b0;
        rd_wdata  = rd_we ? result_reg : 32'b0;
        misalign  = (state_reg == DONE) && mis_reg;
        bus_err   = (state_reg == DONE) && err_reg;
        // Reset gates the combinational path so hold is low throughout reset.
        hold      = !rst && ((state_reg == REQ) || (state_reg == RESP) ||
                             ((state_reg == IDLE) && valid_req));
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: constant vector table, hand-written reset
// sequence and random transactions checked against a behavioural model.
module tb_mem_access;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_re = 1'b0, mem_we = 1'b0, un_sign = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [1:0]  byte_sel = '0;
    logic [4:0]  rd_addr = '0;
    logic        rd_we, hold, misalign, bus_err;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;

    int total = 0;
    int bad   = 0;

    mem_access_if bus_if ();

    mem_access #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .byte_sel (byte_sel),
        .un_sign  (un_sign),
        .rd_addr  (rd_addr),
        .bus      (bus_if.master),
        .rd_we    (rd_we),
        .rd_waddr (rd_waddr),
        .rd_wdata (rd_wdata),
        .hold     (hold),
        .misalign (misalign),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re, we, uns;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] addr, wdata, rdata;
        int          gnt_wait, rv_wait;
    } txn_t;

    typedef struct {
        int          hold, req, mis, err, wb;
        logic        granted, bwe;
        logic [4:0]  rd_waddr;
        logic [3:0]  wstrb;
        logic [31:0] rd_wdata, baddr, bwdata;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic txn_t mk_t(logic re, logic we, logic [1:0] sel, logic uns,
                                  logic [31:0] addr, logic [31:0] wdata,
                                  logic [31:0] rdata, int gw, int rw);
        txn_t t;
        t.re = re; t.we = we; t.sel = sel; t.uns = uns; t.rd = 5'd9;
        t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.gnt_wait = gw; t.rv_wait = rw;
        return t;
    endfunction

    function automatic exp_t mk_e(int hold_c, int req_c, int mis_c, int err_c, int wb_c,
                                  logic [31:0] rdw, logic granted, logic [31:0] baddr,
                                  logic bwe, logic [3:0] wstrb, logic [31:0] bwdata);
        exp_t e;
        e.hold = hold_c; e.req = req_c; e.mis = mis_c; e.err = err_c; e.wb = wb_c;
        e.rd_wdata = rdw; e.rd_waddr = wb_c != 0 ? 5'd9 : 5'd0;
        e.granted = granted; e.baddr = baddr; e.bwe = bwe; e.wstrb = wstrb; e.bwdata = bwdata;
        return e;
    endfunction

    // Reference: sizes in bytes, lane arithmetic and cycle budgets derived from the rules.
    function automatic exp_t model(txn_t t);
        exp_t   e;
        int     size, off, busy;
        longint v, span;
        e = mk_e(0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 4'b0, 0);
        e.rd_waddr = t.rd;
        if (!(t.re || t.we) || t.sel == 2'b11) return e;
        size = 1 << t.sel;
        off  = int'(t.addr % 4);
        if (off % size != 0) begin
            e.hold = 1; e.mis = 1;
            return e;
        end
        e.baddr = t.addr - 32'(off);
        e.bwe   = t.we;
        if (t.we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (lane >= off && lane < off + size) e.wstrb[lane] = 1'b1;
                e.bwdata = e.bwdata | (((t.wdata >> (8 * (lane % size))) & 32'hFF) << (8 * lane));
            end
        end
        if (t.gnt_wait + 1 > TO) begin
            e.hold = 1 + TO; e.req = TO; e.err = 1;
            return e;
        end
        e.granted = 1'b1;
        e.req     = t.gnt_wait + 1;
        busy      = t.we ? t.gnt_wait + 1 : t.gnt_wait + 1 + t.rv_wait + 1;
        if (busy > TO) begin
            e.hold = 1 + TO; e.err = 1;
            return e;
        end
        e.hold = 1 + busy;
        if (!t.we) begin
            span = longint'(1) << (8 * size);
            v = longint'(t.rdata >> (8 * off)) % span;
            if (!t.uns && v >= span / 2) v = v - span;
            e.wb = 1;
            e.rd_wdata = 32'(v);
        end
        return e;
    endfunction

    // Starts one cycle after a rising edge; returns one cycle after the idle cycle following DONE.
    task automatic run_txn(input int idx, input txn_t t, input exp_t e);
        int          hold_c, req_c, mis_c, err_c, wb_c, since, rq_cnt;
        logic        granted, done, finished, bwe;
        logic [3:0]  wstrb;
        logic [31:0] baddr, bwdata, done_wdata;
        logic [4:0]  wb_addr;
        hold_c = 0; req_c = 0; mis_c = 0; err_c = 0; wb_c = 0; since = 0; rq_cnt = 0;
        granted = 1'b0; done = 1'b0; finished = 1'b0; bwe = 1'b0;
        wstrb = '0; baddr = '0; bwdata = '0; done_wdata = '0; wb_addr = '0;
        mem_re = t.re; mem_we = t.we; byte_sel = t.sel; un_sign = t.uns;
        mem_addr = t.addr; mem_wdata = t.wdata; rd_addr = t.rd;
        for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
            bus_if.gnt    = bus_if.req && (rq_cnt >= t.gnt_wait);
            bus_if.rvalid = granted && t.re && !t.we && !done && (since >= t.rv_wait);
            bus_if.rdata  = t.rdata;
            #1;
            if (hold)     hold_c++;
            if (bus_if.req) req_c++;
            if (misalign) mis_c++;
            if (bus_err)  err_c++;
            if (rd_we) begin wb_c++; wb_addr = rd_waddr; end
            if (bus_if.req && bus_if.gnt && !granted) begin
                granted = 1'b1; since = 0;
                baddr = bus_if.addr; bwe = bus_if.we; wstrb = bus_if.wstrb; bwdata = bus_if.wdata;
            end else if (granted) begin
                since++;
            end
            if (bus_if.req) rq_cnt++;
            if (done) begin
                finished = 1'b1;
            end else if (cyc > 0 && !hold) begin
                done = 1'b1;
                done_wdata = rd_wdata;
                mem_re = 1'b0; mem_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0;
        mem_re = 1'b0; mem_we = 1'b0;
        chk($sformatf("t%0d completes", idx), {31'b0, finished}, 32'd1);
        chk($sformatf("t%0d hold_cycles", idx), hold_c, e.hold);
        chk($sformatf("t%0d req_cycles", idx), req_c, e.req);
        chk($sformatf("t%0d misalign", idx), mis_c, e.mis);
        chk($sformatf("t%0d bus_err", idx), err_c, e.err);
        chk($sformatf("t%0d rd_we", idx), wb_c, e.wb);
        chk($sformatf("t%0d rd_wdata", idx), done_wdata, e.rd_wdata);
        if (e.wb != 0) chk($sformatf("t%0d rd_waddr", idx), wb_addr, e.rd_waddr);
        chk($sformatf("t%0d granted", idx), {31'b0, granted}, {31'b0, e.granted});
        if (e.granted && granted) begin
            chk($sformatf("t%0d bus_addr", idx), baddr, e.baddr);
            chk($sformatf("t%0d bus_we", idx), bwe, e.bwe);
            chk($sformatf("t%0d bus_wstrb", idx), wstrb, e.wstrb);
            if (e.bwe) chk($sformatf("t%0d bus_wdata", idx), bwdata, e.bwdata);
        end
        $display("txn %0d re=%0b we=%0b sel=%0d addr=%h hold=%0d req=%0d wb=%0d data=%h mis=%0d err=%0d",
                 idx, t.re, t.we, t.sel, t.addr, hold_c, req_c, wb_c, done_wdata, mis_c, err_c);
    endtask

    function automatic logic [31:0] all_outputs();
        return {bus_if.req, bus_if.we, bus_if.wstrb, rd_we, rd_waddr, hold, misalign, bus_err} |
               bus_if.addr | bus_if.wdata | rd_wdata;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[15];
        txn_t t;
        vecs[0]  = '{mk_t(1,0,2'b00,0,32'h1003,0,32'h80FF_1234,0,0),
                     mk_e(3,1,0,0,1,32'hFFFF_FF80,1,32'h1000,0,4'b0000,0)};
        vecs[1]  = '{mk_t(1,0,2'b01,1,32'h2002,0,32'h8001_5555,0,0),
                     mk_e(3,1,0,0,1,32'h0000_8001,1,32'h2000,0,4'b0000,0)};
        vecs[2]  = '{mk_t(1,0,2'b01,0,32'h2002,0,32'h8001_5555,0,0),
                     mk_e(3,1,0,0,1,32'hFFFF_8001,1,32'h2000,0,4'b0000,0)};
        vecs[3]  = '{mk_t(0,1,2'b00,0,32'h3001,32'h0000_00AB,0,4,0),
                     mk_e(6,5,0,0,0,0,1,32'h3000,1,4'b0010,32'hABAB_ABAB)};
        vecs[4]  = '{mk_t(1,0,2'b10,0,32'h4002,0,0,0,0),
                     mk_e(1,0,1,0,0,0,0,0,0,4'b0000,0)};
        vecs[5]  = '{mk_t(0,1,2'b10,0,32'h0010,32'h1234_5678,0,0,0),
                     mk_e(2,1,0,0,0,0,1,32'h0010,1,4'b1111,32'h1234_5678)};
        vecs[6]  = '{mk_t(1,0,2'b00,1,32'h5002,0,32'h11C0_3344,1,2),
                     mk_e(6,2,0,0,1,32'h0000_00C0,1,32'h5000,0,4'b0000,0)};
        vecs[7]  = '{mk_t(0,1,2'b01,0,32'h6002,32'h7777_BEEF,0,0,0),
                     mk_e(2,1,0,0,0,0,1,32'h6000,1,4'b1100,32'hBEEF_BEEF)};
        vecs[8]  = '{mk_t(1,1,2'b00,0,32'h7000,32'h0000_005A,32'hFFFF_FFFF,0,0),
                     mk_e(2,1,0,0,0,0,1,32'h7000,1,4'b0001,32'h5A5A_5A5A)};
        vecs[9]  = '{mk_t(1,0,2'b01,0,32'h8001,0,0,0,0),
                     mk_e(1,0,1,0,0,0,0,0,0,4'b0000,0)};
        vecs[10] = '{mk_t(1,0,2'b11,0,32'h9000,0,32'h1111_1111,0,0),
                     mk_e(0,0,0,0,0,0,0,0,0,4'b0000,0)};
        vecs[11] = '{mk_t(1,0,2'b10,0,32'h9000,0,32'hDEAD_BEEF,7,7),
                     mk_e(17,8,0,0,1,32'hDEAD_BEEF,1,32'h9000,0,4'b0000,0)};
        vecs[12] = '{mk_t(1,0,2'b10,0,32'hA000,0,32'h1,0,255),
                     mk_e(17,1,0,1,0,0,1,32'hA000,0,4'b0000,0)};
        vecs[13] = '{mk_t(0,1,2'b10,0,32'hB004,32'h5,0,255,0),
                     mk_e(17,16,0,1,0,0,0,0,0,4'b0000,0)};
        vecs[14] = '{mk_t(1,0,2'b00,0,32'hC000,0,32'h0000_007F,0,0),
                     mk_e(3,1,0,0,1,32'h0000_007F,1,32'hC000,0,4'b0000,0)};

        bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", all_outputs(), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle after reset", all_outputs(), 32'd0);

        for (int i = 0; i < 15; i++) run_txn(i, vecs[i].t, vecs[i].e);

        // Reset while a load waits in RESP, request still presented upstream.
        mem_re = 1'b1; mem_we = 1'b0; byte_sel = 2'b10; mem_addr = 32'h20; rd_addr = 5'd7;
        #1; @(posedge clk); #1;
        bus_if.gnt = 1'b1;
        #1;
        chk("rst seq req in REQ", {31'b0, bus_if.req}, 32'd1);
        @(posedge clk); #1;
        bus_if.gnt = 1'b0;
        #1;
        chk("rst seq hold in RESP", {31'b0, hold}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async reset outputs", all_outputs(), 32'd0);
        mem_re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("txn rst during RESP done");
        run_txn(100, mk_t(0,1,2'b10,0,32'h10,32'hCAFE_F00D,0,0,0),
                mk_e(2,1,0,0,0,0,1,32'h10,1,4'b1111,32'hCAFE_F00D));

        for (int i = 0; i < 40; i++) begin
            int r, s;
            r = int'($urandom_range(1, 3));
            s = int'($urandom_range(0, 9));
            t.re = r[0]; t.we = r[1];
            t.sel = (s == 9) ? 2'b11 : 2'(s % 3);
            t.uns = 1'($urandom_range(0, 1));
            t.rd = 5'($urandom_range(0, 31));
            t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom;
            t.gnt_wait = int'($urandom_range(0, 5));
            t.rv_wait = int'($urandom_range(0, 5));
            run_txn(200 + i, t, model(t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
